// File: rtl/yi_writeback_sched.sv
// Y-vector writeback sequencer: pulls row results from the lanes in row order, feeds
// the element packer, pads the last partial word and addresses each packed word.
module yi_writeback_sched #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              precision,
  input  logic [ADDR_W-1:0]       y_base_addr,
  input  logic [CNT_W-1:0]        y_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [NUM_LANES-1:0]    lane_valid,
  input  logic [64*NUM_LANES-1:0] lane_data,
  output logic [NUM_LANES-1:0]    lane_ready,
  output logic [2:0]              pk_sel,
  output logic                    pk_clr,
  output logic                    pk_in_valid,
  output logic [63:0]             pk_in_data,
  input  logic                    pk_in_ready,
  input  logic                    pk_out_valid,
  input  logic [63:0]             pk_out_data,
  output logic                    pk_out_ready,
  output logic                    wr_valid,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [63:0]             wr_data,
  input  logic                    wr_ready
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_PAD, S_DRAIN, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          prec_q, prec_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    elem_idx_q, elem_idx_d;
  logic [CNT_W-1:0]    word_idx_q, word_idx_d;
  logic                err_q, err_d;
  logic                pk_clr_q, pk_clr_d;

  logic [1:0]          epw_mask;
  logic [CNT_W-1:0]    words;
  logic [CNT_W-1:0]    elem_nxt;
  logic [LANE_W-1:0]   cur;
  logic                last_elem;
  logic                len_rem_nz;
  logic                pad_done;
  logic                word_act;

  // EPW-1 as a mask: element index modulo EPW is just the masked low bits.
  always_comb begin
    case (prec_q)
      3'd0:    epw_mask = 2'b11;
      3'd1:    epw_mask = 2'b01;
      default: epw_mask = 2'b00;
    endcase
  end

  always_comb begin
    case (prec_q)
      3'd0:    words = (len_q >> 2) + CNT_W'(|len_q[1:0]);
      3'd1:    words = (len_q >> 1) + CNT_W'(len_q[0]);
      default: words = len_q;
    endcase
  end

  assign elem_nxt   = elem_idx_q + CNT_W'(1);
  assign cur        = LANE_W'(elem_idx_q & CNT_W'(NUM_LANES - 1));
  assign last_elem  = (elem_idx_q == len_q - CNT_W'(1));
  assign len_rem_nz = |(len_q[1:0] & epw_mask);
  assign pad_done   = ~|(elem_nxt[1:0] & epw_mask);
  // Words beyond the expected count are never accepted from the packer.
  assign word_act   = ((state_q == S_RUN) || (state_q == S_PAD) || (state_q == S_DRAIN)) &&
                      (word_idx_q != words);

  assign wr_addr = base_q + ADDR_W'({word_idx_q, 3'b000});
  assign pk_sel  = prec_q;
  assign pk_clr  = pk_clr_q;
  assign err     = err_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    prec_d       = prec_q;
    base_d       = base_q;
    len_d        = len_q;
    elem_idx_d   = elem_idx_q;
    word_idx_d   = word_idx_q;
    err_d        = err_q;
    busy         = 1'b0;
    done         = 1'b0;
    lane_ready   = '0;
    pk_in_valid  = 1'b0;
    pk_in_data   = '0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    pk_out_ready = 1'b0;

    if (word_act) begin
      wr_valid     = pk_out_valid;
      wr_data      = pk_out_data;
      pk_out_ready = wr_ready;
      if (pk_out_valid && wr_ready) word_idx_d = word_idx_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (precision > 3'd2) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (y_len == '0) begin
            state_d = S_FIN;
          end else begin
            prec_d     = precision;
            base_d     = y_base_addr;
            len_d      = y_len;
            elem_idx_d = '0;
            word_idx_d = '0;
            state_d    = S_CLR;
          end
        end
      end
      S_CLR: begin
        busy    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy            = 1'b1;
        pk_in_valid     = lane_valid[cur];
        pk_in_data      = lane_data[64*cur +: 64];
        lane_ready[cur] = pk_in_ready;
        if (lane_valid[cur] && pk_in_ready) begin
          elem_idx_d = elem_nxt;
          if (last_elem) state_d = len_rem_nz ? S_PAD : S_DRAIN;
        end
      end
      S_PAD: begin
        busy        = 1'b1;
        pk_in_valid = 1'b1;
        if (pk_in_ready) begin
          elem_idx_d = elem_nxt;
          if (pad_done) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (word_idx_q == words) state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    pk_clr_d = (state_d == S_CLR);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      prec_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      elem_idx_q <= '0;
      word_idx_q <= '0;
      err_q      <= 1'b0;
      pk_clr_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      prec_q     <= prec_d;
      base_q     <= base_d;
      len_q      <= len_d;
      elem_idx_q <= elem_idx_d;
      word_idx_q <= word_idx_d;
      err_q      <= err_d;
      pk_clr_q   <= pk_clr_d;
    end
  end

endmodule
